// File: rtl/riscv_pkg.sv
// Shared RISC datapath constants and types used by the register file.
package riscv_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : riscv_pkg

// File: rtl/register_file_2r1w_reg_word.sv
// One architectural register word: load-enabled flop bank with async active-high clear.
module reg_word #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : reg_word

// File: rtl/register_file_2r1w.sv
// 32x32 integer register file, one synchronous write port, two combinational read ports, x0 hardwired to zero.
// Optional write-through bypass from write port to read ports when REGFILE_BYPASS_EN is defined.
module register_file_2r1w
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = riscv_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] w_words [NUM_REGS];
    logic                  w_wr_valid;
    logic [DATA_WIDTH-1:0] w_rd1_stored;
    logic [DATA_WIDTH-1:0] w_rd2_stored;

    assign w_wr_valid = we && (waddr != ZERO_IDX);

    // Index 0 has no storage; its mux leg is tied to zero.
    assign w_words[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_word
            logic w_load;

            assign w_load = we && (waddr == ADDR_WIDTH'(gi));

            reg_word #(
                .WIDTH (DATA_WIDTH)
            ) u_word (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_load),
                .i_d    (wdata),
                .o_q    (w_words[gi])
            );
        end
    endgenerate

    // Stored-state read muxes; index 0 forced to zero independently of the array leg.
    always_comb begin
        w_rd1_stored = '0;
        w_rd2_stored = '0;
        if (raddr1 != ZERO_IDX) begin
            w_rd1_stored = w_words[raddr1];
        end
        if (raddr2 != ZERO_IDX) begin
            w_rd2_stored = w_words[raddr2];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Pending write is forwarded to any port reading the same nonzero index.
    always_comb begin
        rdata1 = w_rd1_stored;
        rdata2 = w_rd2_stored;
        if (!rst && w_wr_valid && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (!rst && w_wr_valid && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end
`else
    logic w_unused_wr_valid;

    assign w_unused_wr_valid = w_wr_valid;
    assign rdata1            = w_rd1_stored;
    assign rdata2            = w_rd2_stored;
`endif

endmodule : register_file_2r1w
